// File: rtl/video_tb_pkg.sv
// Shared definitions for the video pattern generator: FSM state encoding,
// counter widths and the geometry latch helper.
package video_tb_pkg;

  localparam int GEOM_W      = 12;
  localparam int PIX_CNT_W   = 16;
  localparam int BLANK_CNT_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    LINE,
    HBLANK,
    TAIL,
    VBLANK
  } state_t;

  // Geometry is stored as (value - 1); a programmed 0 behaves like 1.
  function automatic logic [GEOM_W-1:0] geom_latch_m1(input logic [GEOM_W-1:0] v);
    return (v == '0) ? '0 : v - GEOM_W'(1);
  endfunction

endpackage

// File: rtl/video_pattern_gen_if.sv
// Frame/line valid plus pixel bus between a video source and its sink.
// Timing contract: o_lval is only high while o_fval is high, ov_pix_data
// carries a beat on every cycle with o_lval=1 and is zero otherwise, and
// o_frame_done pulses for one cycle on the first fval-low cycle of a frame.
// There is no back-pressure: the sink must accept every beat.
interface video_pattern_gen_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int CHANNEL_NUM = 4
);
  logic                              o_fval;
  logic                              o_lval;
  logic [DATA_WIDTH*CHANNEL_NUM-1:0] ov_pix_data;
  logic                              o_frame_done;

  modport master (
    output o_fval,
    output o_lval,
    output ov_pix_data,
    output o_frame_done
  );

  modport slave (
    input o_fval,
    input o_lval,
    input ov_pix_data,
    input o_frame_done
  );
endinterface

// File: rtl/video_pattern_data.sv
// Pixel counter and per-channel ramp composer. Channel k of the bus is
// (pix_cnt + k) truncated to DATA_WIDTH; the counter steps by CHANNEL_NUM
// per beat and wraps modulo 2^PIX_CNT_W.
module video_pattern_data
  import video_tb_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int CHANNEL_NUM = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              clear,
  input  logic [PIX_CNT_W-1:0]              seed,
  input  logic                              advance,
  output logic [DATA_WIDTH*CHANNEL_NUM-1:0] data
);

  logic [PIX_CNT_W-1:0] pix_cnt;

  // Counter: reload with the frame seed at frame start, step per emitted beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_cnt <= '0;
    end else if (clear) begin
      pix_cnt <= seed;
    end else if (advance) begin
      pix_cnt <= pix_cnt + PIX_CNT_W'(CHANNEL_NUM);
    end
  end

  // Ramp composer: one incrementing value per channel lane.
  always_comb begin
    data = '0;
    for (int k = 0; k < CHANNEL_NUM; k++) begin
      data[k*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(pix_cnt + PIX_CNT_W'(k));
    end
  end

endmodule

// File: rtl/video_pattern_gen.sv
// Programmable-geometry video source: frame valid, line valid and a ramp
// pixel pattern, with lead/tail/blanking intervals set by parameters and
// line/frame size latched from inputs at each frame start.
// Optional build macro VIDEO_PATTERN_FRAME_SEED_EN: a frame counter seeds
// the ramp so every frame starts at a different value.
module video_pattern_gen
  import video_tb_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int CHANNEL_NUM = 4,
  parameter int FVAL_LEAD   = 4,
  parameter int FVAL_TAIL   = 4,
  parameter int H_BLANK     = 16,
  parameter int V_BLANK     = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_gen_en,
  input  logic [GEOM_W-1:0]   iv_line_beats,
  input  logic [GEOM_W-1:0]   iv_frame_lines,
  video_pattern_gen_if.master vid,
  output state_t              dbg_state
);

  localparam int BUS_W = DATA_WIDTH * CHANNEL_NUM;

  localparam logic [BLANK_CNT_W-1:0] LEAD_LAST   = BLANK_CNT_W'(FVAL_LEAD - 1);
  localparam logic [BLANK_CNT_W-1:0] TAIL_LAST   = BLANK_CNT_W'(FVAL_TAIL - 1);
  localparam logic [BLANK_CNT_W-1:0] HBLANK_LAST = BLANK_CNT_W'(H_BLANK - 1);
  localparam logic [BLANK_CNT_W-1:0] VBLANK_LAST = BLANK_CNT_W'(V_BLANK - 1);

  state_t                 state, state_next;
  logic [GEOM_W-1:0]      beat_cnt, beat_next;
  logic [GEOM_W-1:0]      line_cnt, line_next;
  logic [BLANK_CNT_W-1:0] blank_cnt, blank_next;
  logic [GEOM_W-1:0]      beats_m1, lines_m1;
  logic                   latch_en;
  logic                   pix_advance;
  logic                   done_set;
  logic [PIX_CNT_W-1:0]   seed;
  logic [BUS_W-1:0]       ramp;

  logic                   fval_q;
  logic                   lval_q;
  logic [BUS_W-1:0]       pix_q;
  logic                   done_q;

  // First VBLANK cycle: the frame is over, fval falls on the next edge.
  assign done_set = (state == VBLANK) && (blank_cnt == '0);

  // State and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      line_cnt  <= '0;
      blank_cnt <= '0;
    end else begin
      state     <= state_next;
      beat_cnt  <= beat_next;
      line_cnt  <= line_next;
      blank_cnt <= blank_next;
    end
  end

  // Next-state and counter sequencing; a single blank counter times
  // LEAD, HBLANK, TAIL and VBLANK since only one is active at a time.
  always_comb begin
    state_next  = state;
    beat_next   = beat_cnt;
    line_next   = line_cnt;
    blank_next  = blank_cnt;
    latch_en    = 1'b0;
    pix_advance = 1'b0;
    case (state)
      IDLE: begin
        if (i_gen_en) begin
          latch_en   = 1'b1;
          state_next = LEAD;
          blank_next = '0;
        end
      end
      LEAD: begin
        if (blank_cnt == LEAD_LAST) begin
          state_next = LINE;
          blank_next = '0;
          beat_next  = '0;
          line_next  = '0;
        end else begin
          blank_next = blank_cnt + BLANK_CNT_W'(1);
        end
      end
      LINE: begin
        pix_advance = 1'b1;
        if (beat_cnt == beats_m1) begin
          beat_next  = '0;
          blank_next = '0;
          if (line_cnt == lines_m1) begin
            state_next = TAIL;
          end else begin
            state_next = HBLANK;
            line_next  = line_cnt + GEOM_W'(1);
          end
        end else begin
          beat_next = beat_cnt + GEOM_W'(1);
        end
      end
      HBLANK: begin
        if (blank_cnt == HBLANK_LAST) begin
          state_next = LINE;
          blank_next = '0;
        end else begin
          blank_next = blank_cnt + BLANK_CNT_W'(1);
        end
      end
      TAIL: begin
        if (blank_cnt == TAIL_LAST) begin
          state_next = VBLANK;
          blank_next = '0;
        end else begin
          blank_next = blank_cnt + BLANK_CNT_W'(1);
        end
      end
      VBLANK: begin
        if (blank_cnt == VBLANK_LAST) begin
          blank_next = '0;
          if (i_gen_en) begin
            latch_en   = 1'b1;
            state_next = LEAD;
          end else begin
            state_next = IDLE;
          end
        end else begin
          blank_next = blank_cnt + BLANK_CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Geometry latch: sizes only change at a frame start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beats_m1 <= '0;
      lines_m1 <= '0;
    end else if (latch_en) begin
      beats_m1 <= geom_latch_m1(iv_line_beats);
      lines_m1 <= geom_latch_m1(iv_frame_lines);
    end
  end

`ifdef VIDEO_PATTERN_FRAME_SEED_EN
  logic [PIX_CNT_W-1:0] frame_cnt;

  // Frame counter: one step per completed frame, cleared by reset only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt <= '0;
    end else if (done_set) begin
      frame_cnt <= frame_cnt + PIX_CNT_W'(1);
    end
  end

  // With a one-cycle VBLANK the count step and the reseed share an edge.
  assign seed = done_set ? frame_cnt + PIX_CNT_W'(1) : frame_cnt;
`else
  assign seed = '0;
`endif

  video_pattern_data #(
    .DATA_WIDTH  (DATA_WIDTH),
    .CHANNEL_NUM (CHANNEL_NUM)
  ) u_data (
    .clk     (clk),
    .reset   (reset),
    .clear   (latch_en),
    .seed    (seed),
    .advance (pix_advance),
    .data    (ramp)
  );

  // Output registers decoded from the current state, one cycle behind it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fval_q <= 1'b0;
      lval_q <= 1'b0;
      pix_q  <= '0;
      done_q <= 1'b0;
    end else begin
      fval_q <= (state == LEAD) || (state == LINE) || (state == HBLANK) || (state == TAIL);
      lval_q <= (state == LINE);
      pix_q  <= (state == LINE) ? ramp : '0;
      done_q <= done_set;
    end
  end

  assign vid.o_fval       = fval_q;
  assign vid.o_lval       = lval_q;
  assign vid.ov_pix_data  = pix_q;
  assign vid.o_frame_done = done_q;
  assign dbg_state        = state;

endmodule

// File: doc/video_pattern_gen.md
Name: video_pattern_gen

Overview:
- Synthesizable, parameterised video source. Drives frame valid, line valid and multi-channel pixel data with a deterministic ramp pattern.
- Feeds a DUT input and the input side of the team's in/out data checker.
- Other end of the fval/lval/pixel-bus interface: generates, where the checker consumes.
- Frame geometry and blanking are programmable, so buffering DUTs can be stressed at line and frame boundaries.

Parameters:
- DATA_WIDTH, 8, bits per channel.
- CHANNEL_NUM, 4, pixels per beat.
- FVAL_LEAD, 4, cycles fval is high before the first lval of a frame (min 1).
- FVAL_TAIL, 4, cycles fval stays high after the last lval (min 1).
- H_BLANK, 16, lval-low cycles between lines inside a frame (min 1).
- V_BLANK, 32, fval-low cycles between frames (min 1).

Ports:
- clk  in  1  single clock domain.
- reset  in  1  asynchronous, active-high reset.
- i_gen_en  in  1  generation enable, sampled at frame boundaries only.
- iv_line_beats  in  12  beats per line, sampled at frame start (range 1..4095).
- iv_frame_lines  in  12  lines per frame, sampled at frame start (range 1..4095).
- o_fval  out  1  frame valid.
- o_lval  out  1  line valid; high only while o_fval is high.
- ov_pix_data  out  DATA_WIDTH*CHANNEL_NUM  pixel beat; channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- o_frame_done  out  1  one-cycle pulse on the first cycle after o_fval falls.

Behaviour:
- Reset values: all outputs 0, state IDLE, all counters 0. Reset asserted mid-frame aborts immediately: o_fval and o_lval drop asynchronously and no o_frame_done pulse is issued.
- Outputs are fully registered.
- State machine:
  - IDLE: when i_gen_en=1 at edge N, latch sizes and go to LEAD; o_fval=1 from edge N+1.
  - LEAD: o_fval=1 for FVAL_LEAD cycles, then LINE.
  - LINE: o_fval=1 and o_lval=1 for exactly the latched iv_line_beats cycles. After the last beat, go to HBLANK if lines remain, else TAIL.
  - HBLANK: o_lval=0 for H_BLANK cycles, then LINE.
  - TAIL: o_fval=1, o_lval=0 for FVAL_TAIL cycles, then VBLANK.
  - VBLANK: o_fval=0 for V_BLANK cycles; o_frame_done=1 on the first VBLANK cycle. On the last VBLANK cycle, if i_gen_en=1, re-latch sizes and go to LEAD; else go to IDLE.
- i_gen_en deasserted mid-frame: the current frame completes fully, then the block goes to IDLE.
- iv_line_beats and iv_frame_lines changes mid-frame are ignored until the next latch.
- An input value of 0 is clamped to 1 when latched.
- Pattern:
  - 16-bit pixel counter pix_cnt is cleared at each frame start.
  - On each LINE beat, channel k = (pix_cnt + k) mod 2^DATA_WIDTH; pix_cnt then advances by CHANNEL_NUM. Wrap is modulo 2^16, then truncated to DATA_WIDTH.
  - ov_pix_data is 0 whenever o_lval=0.
- Line and beat counters are 12 bits and compare against the latched value minus 1. No wrap occurs within the legal range.
- Back-to-back frames are separated by exactly V_BLANK fval-low cycles.

Optional Feature:
- Macro: VIDEO_PATTERN_FRAME_SEED_EN.
- Defined: a 16-bit frame counter increments on each o_frame_done pulse and seeds pix_cnt at frame start. Frame F, pixel 0 therefore equals F mod 2^DATA_WIDTH, so a dropped or repeated frame becomes visible to the checker. The counter clears on reset only.
- Undefined: pix_cnt is seeded with 0 every frame, and no frame counter is instantiated.

Decomposition:
- Shared package video_tb_pkg holds:
  - state enum (IDLE, LEAD, LINE, HBLANK, TAIL, VBLANK);
  - 12-bit geometry width constant (GEOM_W = 12);
  - 16-bit PIX_CNT_W constant.
- One natural sub-module: video_pattern_data, the pix_cnt register plus the per-channel ramp composer. Inputs are clear, seed and advance; output is the data bus.
- Timing FSM and counters stay in the top module.

Test Plan:
- Basic frame, defaults, line_beats=4, frame_lines=2, i_gen_en pulsed 1 cycle:
  - o_fval high 4+4+16+4+4=32 cycles;
  - two lval bursts of 4 separated by 16;
  - first beat 0x03020100, last beat 0x1F1E1D1C;
  - o_frame_done pulses once;
  - block returns to IDLE.
- Continuous enable, 3 frames, line_beats=8, frame_lines=3:
  - exactly 32 fval-low cycles between frames;
  - each frame's first beat is 0x03020100 (feature off);
  - 3 o_frame_done pulses.
- Geometry change mid-frame (line_beats 8 -> 2 during frame 0):
  - frame 0 keeps 8-beat lines;
  - frame 1 uses 2-beat lines.
- Zero geometry, line_beats=0, frame_lines=0 -> a single 1-beat line with data 0x03020100.
- Reset asserted on the 3rd beat of line 1:
  - o_fval, o_lval and ov_pix_data are 0 immediately;
  - no o_frame_done;
  - after release with i_gen_en=1, a clean frame restarts at 0x03020100.
- Loopback with the in/out data checker (DUT = wire, STOP_ON_ERROR=1) for 10 frames at line_beats=100 -> zero mismatches. With VIDEO_PATTERN_FRAME_SEED_EN, frame 5's first beat is 0x08070605.
